// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl -- fetch-stage PC sequencer for the RV32I 5-stage core.
//
// Owns the architectural fetch PC, runs the instruction-memory req/ack
// handshake, applies EX redirects (or the predicted next PC), presents
// fetched words to IF/ID with valid/ready, raises the IF/ID and ID/EX
// flushes, and drains fetches that a redirect has killed.
//
// Optional feature: define PC_CTRL_MISALIGN_TRAP_EN to send misaligned
// redirect targets to TRAP_VEC and pulse misalign_trap. Without it the
// target's low two bits are cleared and misalign_trap is tied low.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pc                current fetch PC (feeds the external predictor)
//   predict_target    next PC when no redirect
//   redirect_valid    EX-resolved control-flow change this cycle
//   redirect_target   prioritised br/jalr/jal target
//   stall             hazard freeze of IF
//   imem_req/addr     fetch request; addr held until ack
//   imem_ack/rdata    one-cycle ack with fetched word
//   if_valid/ready    IF/ID handshake
//   if_pc/if_instr    presented instruction and its PC
//   flush_if_id/id_ex combinational flushes (= redirect_valid)
//   redirect_cnt      wrapping count of redirect cycles
//   misalign_trap     one-cycle pulse after a misaligned redirect
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] predict_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [15:0] redirect_cnt,
    output logic        misalign_trap
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;
    state_t state;

    logic [31:0] redir_pc;

    assign flush_if_id = redirect_valid;
    assign flush_id_ex = redirect_valid;

`ifdef PC_CTRL_MISALIGN_TRAP_EN
    logic redir_mis;
    assign redir_mis = (redirect_target[1:0] != 2'b00);
    assign redir_pc  = redir_mis ? TRAP_VEC : redirect_target;

    always_ff @(posedge clk) begin
        if (!rst_n) misalign_trap <= 1'b0;
        else        misalign_trap <= redirect_valid && redir_mis;
    end
`else
    assign redir_pc      = redirect_target & 32'hFFFF_FFFC;
    assign misalign_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_instr     <= NOP;
            redirect_cnt <= 16'h0;
        end else begin
            if (redirect_valid) redirect_cnt <= redirect_cnt + 16'd1;

            case (state)
                IDLE: begin
                    // A late ack from before reset lands here and is ignored.
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect_valid) begin
                        pc        <= redir_pc;
                        imem_addr <= redir_pc;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redir_pc;
                        // Ack in the redirect cycle: drop the word and
                        // re-request at once; otherwise the killed request
                        // must still complete, so keep its address up.
                        if (imem_ack) imem_addr <= redir_pc;
                        else          state     <= DRAIN;
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        pc       <= predict_target;
                        if_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= VALID;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) pc <= redir_pc;
                    // Leaving on the killed ack; a redirect in the same cycle
                    // goes straight to the new target so we never wait on an
                    // ack that will not come.
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_addr <= redirect_valid ? redir_pc : pc;
                    end
                end
                VALID: begin
                    if (redirect_valid) begin
                        if_valid  <= 1'b0;
                        pc        <= redir_pc;
                        imem_req  <= 1'b1;
                        imem_addr <= redir_pc;
                        state     <= FETCH;
                    end else if (if_ready && !stall) begin
                        if_valid  <= 1'b0;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Testbench for fetch_pc_ctrl: directed scenarios followed by a randomized
// run checked against an instruction-stream reference model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] predict_target;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [15:0] redirect_cnt;
    logic        misalign_trap;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          pred_jump = 1'b0;

    always #5 clk = ~clk;

    // Predictor: pc+4, or a fixed forward jump at some addresses in random mode.
    function automatic logic [31:0] pred_fn(input logic [31:0] a);
        if (pred_jump && a[5:2] == 4'hF) return a + 32'h40;
        return a + 32'h4;
    endfunction

    assign predict_target = pred_fn(pc);

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1;
    endfunction

    // Where the fetch stream resumes after a redirect.
    function automatic logic [31:0] eff_fn(input logic [31:0] t);
        if (TRAP_EN) return (t[1:0] != 2'b00) ? TRAP_VEC : t;
        return {t[31:2], 2'b00};
    endfunction

    fetch_pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .predict_target(predict_target),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_cnt(redirect_cnt), .misalign_trap(misalign_trap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || pc !== RESET_PC) begin
            errors++;
            $display("FAIL reset_fetch: req=%b addr=%h pc=%h, want 0/%h/%h", imem_req, imem_addr, pc, RESET_PC, RESET_PC);
        end
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP) begin
            errors++;
            $display("FAIL reset_ifid: valid=%b pc=%h instr=%h, want 0/0/%h", if_valid, if_pc, if_instr, NOP);
        end
        checks++;
        if (redirect_cnt !== 16'h0 || misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: cnt=%h trap=%b, want 0/0", redirect_cnt, misalign_trap);
        end
    endtask

    // Addresses 0,4,8 with 1-cycle ack; if_valid high one cycle in three.
    task automatic test_sequential();
        rst_n = 1'b1;
        if_ready = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_req%0d: req=%b addr=%h valid=%b, want 1/%h/0", k, imem_req, imem_addr, if_valid, 32'(4 * k));
            end
            step();
            imem_ack = 1'b1;
            imem_rdata = mem_fn(32'(4 * k));
            step();
            imem_ack = 1'b0;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== mem_fn(32'(4 * k)) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL seq_valid%0d: valid=%b pc=%h instr=%h req=%b, want 1/%h/%h/0", k, if_valid, if_pc, if_instr, imem_req, 32'(4 * k), mem_fn(32'(4 * k)));
            end
            step();
        end
    endtask

    // VALID held by if_ready=0 for 4 cycles; fetch resumes 1 cycle after ready.
    task automatic test_hold();
        step();
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        if_ready = 1'b0;
        step();
        imem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'h0050_0093 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b pc=%h instr=%h req=%b, want 1/c/00500093/0", k, if_valid, if_pc, if_instr, imem_req);
            end
            step();
        end
        if_ready = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: req=%b addr=%h valid=%b, want 1/10/0", imem_req, imem_addr, if_valid);
        end
    endtask

    // Redirect in FETCH before ack; the killed word must never be presented.
    task automatic test_redirect_drain();
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        #1;
        checks++;
        if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL drain_flush: if_id=%b id_ex=%b, want 1/1", flush_if_id, flush_id_ex);
        end
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc !== 32'h200 || flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold: req=%b addr=%h pc=%h flush=%b, want 1/10/200/0", imem_req, imem_addr, pc, flush_if_id);
        end
        step();
        step();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0 || redirect_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drain_exit: req=%b addr=%h valid=%b cnt=%0d, want 1/200/0/1", imem_req, imem_addr, if_valid, redirect_cnt);
        end
        step();
        imem_ack = 1'b1;
        imem_rdata = mem_fn(32'h200);
        step();
        imem_ack = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_fn(32'h200)) begin
            errors++;
            $display("FAIL drain_refetch: valid=%b pc=%h instr=%h, want 1/200/%h", if_valid, if_pc, if_instr, mem_fn(32'h200));
        end
    endtask

    // Redirect and ack together: data dropped, new request next cycle.
    task automatic test_redirect_with_ack();
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
            errors++;
            $display("FAIL rwa_req: req=%b addr=%h, want 1/204", imem_req, imem_addr);
        end
        step();
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        step();
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b0 || redirect_cnt !== 16'd2) begin
            errors++;
            $display("FAIL rwa_redirect: req=%b addr=%h valid=%b cnt=%0d, want 1/40/0/2", imem_req, imem_addr, if_valid, redirect_cnt);
        end
        step();
        imem_ack = 1'b1;
        imem_rdata = mem_fn(32'h40);
        step();
        imem_ack = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem_fn(32'h40)) begin
            errors++;
            $display("FAIL rwa_refetch: valid=%b pc=%h instr=%h, want 1/40/%h", if_valid, if_pc, if_instr, mem_fn(32'h40));
        end
    endtask

    // Stall together with redirect in VALID: redirect wins.
    task automatic test_stall_redirect();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        step();
        stall = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80 || redirect_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_redirect: valid=%b req=%b addr=%h cnt=%0d, want 0/1/80/3", if_valid, imem_req, imem_addr, redirect_cnt);
        end
    endtask

    // Misaligned target, then reset mid-DRAIN and a stale ack after reset.
    task automatic test_misalign_reset();
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (pc !== 32'h100 || misalign_trap !== TRAP_EN || imem_addr !== 32'h80 || redirect_cnt !== 16'd4) begin
            errors++;
            $display("FAIL mis_redirect: pc=%h trap=%b addr=%h cnt=%0d, want 100/%b/80/4", pc, misalign_trap, imem_addr, redirect_cnt, TRAP_EN);
        end
        step();
        checks++;
        if (misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: trap=%b, want 0", misalign_trap);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL mis_fetch: req=%b addr=%h, want 1/100", imem_req, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || pc !== 32'h300) begin
            errors++;
            $display("FAIL mis_drain: req=%b addr=%h pc=%h, want 1/100/300", imem_req, imem_addr, pc);
        end
        rst_n = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || pc !== RESET_PC || if_valid !== 1'b0 ||
            if_pc !== 32'h0 || if_instr !== NOP || redirect_cnt !== 16'h0 || misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset: req=%b addr=%h pc=%h valid=%b ifpc=%h instr=%h cnt=%h trap=%b",
                     imem_req, imem_addr, pc, if_valid, if_pc, if_instr, redirect_cnt, misalign_trap);
        end
        rst_n = 1'b1;
        imem_ack = 1'b1;   // late ack from the killed fetch arrives in IDLE
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_ack1: req=%b addr=%h valid=%b, want 1/%h/0", imem_req, imem_addr, if_valid, RESET_PC);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_ack2: req=%b valid=%b, want 1/0", imem_req, if_valid);
        end
    endtask

    // Random traffic; the model tracks only the architectural instruction
    // stream: which PC must be accepted next, and what word it carries.
    task automatic test_random();
        logic [31:0] exp_next_pc = RESET_PC;
        int unsigned model_cnt = 0;
        bit          exp_trap = 1'b0;
        bit          prev_redirect = 1'b0, prev_hold = 1'b0;
        logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0;
        bit          pend = 1'b0;
        logic [31:0] pend_addr = 32'h0;
        int          pend_cnt = 0;
        int unsigned transfers = 0;
        bit          xfer;

        rst_n = 1'b0;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        pred_jump = 1'b1;
        step();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            checks++;
            if (redirect_cnt !== model_cnt[15:0] || misalign_trap !== exp_trap) begin
                errors++;
                $display("FAIL rnd_cnt c%0d: cnt=%0d trap=%b, want %0d/%b", cyc, redirect_cnt, misalign_trap, model_cnt[15:0], exp_trap);
            end
            if (prev_redirect) begin
                checks++;
                if (if_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_kill c%0d: valid=%b, want 0", cyc, if_valid);
                end
            end else if (prev_hold) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
                    errors++;
                    $display("FAIL rnd_hold c%0d: valid=%b pc=%h instr=%h, want 1/%h/%h", cyc, if_valid, if_pc, if_instr, prev_pc, prev_instr);
                end
            end
            // Memory responder: 1..3 cycle ack, address must stay put.
            imem_ack = 1'b0;
            if (pend) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
                    errors++;
                    $display("FAIL rnd_addr c%0d: req=%b addr=%h, want 1/%h", cyc, imem_req, imem_addr, pend_addr);
                end
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_fn(pend_addr);
                    pend = 1'b0;
                end
            end else if (imem_req === 1'b1) begin
                pend = 1'b1;
                pend_addr = imem_addr;
                pend_cnt = $urandom_range(1, 3);
            end
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
            stall = ($urandom_range(0, 3) == 0);
            if_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (flush_if_id !== redirect_valid || flush_id_ex !== redirect_valid) begin
                errors++;
                $display("FAIL rnd_flush c%0d: if_id=%b id_ex=%b, want %b", cyc, flush_if_id, flush_id_ex, redirect_valid);
            end
            xfer = if_valid && if_ready && !stall && !redirect_valid;
            if (xfer) begin
                checks++;
                if (if_pc !== exp_next_pc || if_instr !== mem_fn(exp_next_pc)) begin
                    errors++;
                    $display("FAIL rnd_stream c%0d: pc=%h instr=%h, want %h/%h", cyc, if_pc, if_instr, exp_next_pc, mem_fn(exp_next_pc));
                end
                exp_next_pc = pred_fn(if_pc);
                transfers++;
            end
            exp_trap = 1'b0;
            if (redirect_valid) begin
                exp_next_pc = eff_fn(redirect_target);
                model_cnt++;
                exp_trap = TRAP_EN && (redirect_target[1:0] != 2'b00);
            end
            prev_redirect = redirect_valid;
            prev_hold = if_valid && !xfer && !redirect_valid;
            prev_pc = if_pc;
            prev_instr = if_instr;
        end
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if (transfers < 50) begin
            errors++;
            $display("FAIL rnd_progress: %0d instructions accepted, want at least 50", transfers);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_drain();
        test_redirect_with_ack();
        test_stall_redirect();
        test_misalign_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
